otfs_dd_grid_buffer: RTL and testbench
======================================

Name: otfs_dd_grid_buffer

Overview:
- Sits directly downstream of the 32-QAM modulator.
- Collects one frame of M*N modulated complex symbols into the OTFS delay-Doppler grid using ping-pong storage.
- Streams each completed grid to the ISFFT stage with valid/ready backpressure.
- Input symbols arrive delay-index-fastest. Output is Doppler-index-fastest (transposed), so the ISFFT sees one delay row per N-point transform.

Parameters:
- M, 16, delay bins per grid (power of 2, 2..64).
- N, 8, Doppler bins per grid (power of 2, 2..64).
- DW, 12, signed width of each I/Q component.

Ports:
- Clk  in  1  system clock, rising edge.
- ARstN  in  1  asynchronous active-low reset.
- ModDataInValid  in  1  input symbol strobe.
- FrameBeginIn  in  1  high with the first symbol of a frame.
- FrameNumIn  in  8  frame number; sampled with FrameBeginIn.
- DataInRe  in  DW  signed in-phase.
- DataInIm  in  DW  signed quadrature.
- DataOutValid  out  1  output symbol valid.
- DataOutReady  in  1  downstream accept.
- DataOutRe  out  DW  signed in-phase.
- DataOutIm  out  DW  signed quadrature.
- FrameStartOut  out  1  high on the first output symbol of a grid.
- FrameEndOut  out  1  high on the last output symbol of a grid.
- FrameNumOut  out  8  frame number of the grid being read.
- DelayIdx  out  log2(M)  delay index of the current output.
- DopplerIdx  out  log2(N)  Doppler index of the current output.
- Overflow  out  1  sticky: symbol dropped because both banks were full.
- FrameErr  out  1  sticky: FrameBeginIn arrived while a grid was partially filled.

Behaviour:
- Reset: all outputs 0; both banks empty; write and read FSMs idle; write bank pointer 0; read bank pointer 0.
- Storage: two banks, each M*N x 2*DW, synchronous read.
- Input symbol j of a frame is written to address j, with l = j mod M and k = j / M.
- Write FSM:
  - W_IDLE: ModDataInValid & FrameBeginIn & target bank empty -> write symbol 0, latch FrameNumIn, go to W_FILL.
  - W_IDLE: ModDataInValid without FrameBeginIn -> symbol ignored, no flag.
  - W_FILL: each valid symbol is written and the write counter increments.
  - W_FILL, symbol M*N-1 written: mark bank full, toggle the write bank, go to W_IDLE.
- FrameBeginIn in W_FILL (counter != 0):
  - set FrameErr;
  - discard the partial grid;
  - restart at address 0 of the same bank with this symbol and latch the new FrameNumIn.
- Target bank still full at a frame start: set Overflow; drop the whole incoming frame up to its next FrameBeginIn; write FSM stays in W_IDLE.
- Read FSM:
  - R_IDLE: read bank full -> R_DRAIN.
  - R_DRAIN: issues addresses in the order l outer (0..M-1), k inner (0..N-1); address = k*M + l.
  - R_DRAIN, last address issued: R_IDLE.
- Read pipeline:
  - 1-cycle RAM latency plus one output register.
  - First DataOutValid appears 2 cycles after the bank becomes full, when the read side is idle.
  - Address advances only when the output register is empty or is being accepted (DataOutValid & DataOutReady).
  - While DataOutReady is low, all outputs hold stable.
  - With DataOutReady held high: one symbol per cycle, M*N cycles per grid, no bubbles between back-to-back full banks.
- Bank release: a bank is marked empty on the cycle its FrameEndOut symbol is accepted. A write to that bank may start on the next cycle.
- Simultaneous release of a bank and a frame start targeting it: the frame start sees the bank full -> Overflow.
- Overflow and FrameErr are cleared only by reset.
- Reset mid-operation: counters, flags and bank states are cleared immediately; RAM contents are don't-care.

Optional Feature:
- Macro: OTFS_GRID_TRANSPOSE_EN.
- Defined: transposed read order as described in Behaviour.
- Undefined: the read address equals a linear counter 0..M*N-1, i.e. output in input order with delay fastest. DelayIdx/DopplerIdx still report the correct l/k for each output symbol.

Test Plan:
- Test parameters: M=4, N=2.
- Single frame: FrameBeginIn on the first of 8 symbols with Re=0..7, FrameNumIn=0x05, DataOutReady=1 -> output Re order 0,4,1,5,2,6,3,7. FrameStartOut on the first output, FrameEndOut on the last, FrameNumOut=0x05, first output 2 cycles after symbol 7 is written.
- Backpressure: repeat the single-frame test with DataOutReady toggling 1,0,0,1,... -> identical output sequence; no symbol duplicated or lost; outputs stable while Ready=0.
- Ping-pong / overflow: DataOutReady=0; send three back-to-back 8-symbol frames numbered 1, 2, 3 -> Overflow=1. Release Ready -> frames 1 and 2 output in order, frame 3 absent.
- Frame error: FrameBeginIn, 3 symbols, then FrameBeginIn with 8 symbols Re=10..17 -> FrameErr=1; output Re 10,14,11,15,12,16,13,17.
- Async reset: assert ARstN low mid-drain at output index 3 -> all outputs 0 immediately. Afterwards a fresh frame is output correctly from index 0.
- Macro undefined: single-frame stimulus -> output Re order 0..7; DelayIdx 0,1,2,3,0,1,2,3; DopplerIdx 0,0,0,0,1,1,1,1.

Source files
------------

// File: rtl/otfs_dd_grid_buffer.sv
// Ping-pong delay-Doppler grid buffer between the QAM mapper and the ISFFT.
// Define OTFS_GRID_TRANSPOSE_EN for Doppler-fastest read order; default reads in input order.
module otfs_dd_grid_buffer #(
  parameter int M  = 16,
  parameter int N  = 8,
  parameter int DW = 12
) (
  input  logic                 Clk,
  input  logic                 ARstN,
  input  logic                 ModDataInValid,
  input  logic                 FrameBeginIn,
  input  logic [7:0]           FrameNumIn,
  input  logic [DW-1:0]        DataInRe,
  input  logic [DW-1:0]        DataInIm,
  output logic                 DataOutValid,
  input  logic                 DataOutReady,
  output logic [DW-1:0]        DataOutRe,
  output logic [DW-1:0]        DataOutIm,
  output logic                 FrameStartOut,
  output logic                 FrameEndOut,
  output logic [7:0]           FrameNumOut,
  output logic [$clog2(M)-1:0] DelayIdx,
  output logic [$clog2(N)-1:0] DopplerIdx,
  output logic                 Overflow,
  output logic                 FrameErr
);
  localparam int LM = $clog2(M);
  localparam int LN = $clog2(N);
  localparam int AW = LM + LN;
  localparam int MN = M * N;

  typedef enum logic {W_IDLE, W_FILL}  wstate_e;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

  typedef struct packed {
    logic [LM-1:0] l;
    logic [LN-1:0] k;
    logic          first;
    logic          last;
    logic          bank;
    logic [7:0]    fnum;
  } meta_t;

  logic [2*DW-1:0] mem [2*MN];
  logic [2*DW-1:0] rdata_q;

  wstate_e       wst_q, wst_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]    full_q, full_d;
  logic [1:0][7:0] fnum_q, fnum_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic          we;
  logic [AW-1:0] waddr;

  rstate_e       rst_q, rst_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  meta_t         s1_q, s1_d, out_q, out_d, iss_meta;
  logic [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic          adv, issue;
  logic [AW-1:0] ra;
  logic [LM-1:0] il;
  logic [LN-1:0] ik;

  // Write side: frame capture, restart on early FrameBeginIn, overflow drop.
  always_comb begin
    wst_d     = wst_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    fnum_d    = fnum_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    full_d    = full_q;
    we        = 1'b0;
    waddr     = wr_cnt_q;
    if (vld_pipe_q[1] && DataOutReady && out_q.last) full_d[out_q.bank] = 1'b0;
    case (wst_q)
      W_IDLE: begin
        if (ModDataInValid && FrameBeginIn) begin
          // full_q is pre-release, so a same-cycle release still counts as full
          if (!full_q[wr_bank_q]) begin
            we                = 1'b1;
            waddr             = '0;
            fnum_d[wr_bank_q] = FrameNumIn;
            wr_cnt_d          = AW'(1);
            wst_d             = W_FILL;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (ModDataInValid) begin
          we = 1'b1;
          if (FrameBeginIn) begin
            waddr             = '0;
            ferr_d            = 1'b1;
            fnum_d[wr_bank_q] = FrameNumIn;
            wr_cnt_d          = AW'(1);
          end else if (&wr_cnt_q) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
            wst_d             = W_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
`ifdef OTFS_GRID_TRANSPOSE_EN
    il = rd_cnt_q[AW-1:LN];
    ik = rd_cnt_q[LN-1:0];
    ra = {ik, il};
`else
    il = rd_cnt_q[LM-1:0];
    ik = rd_cnt_q[AW-1:LM];
    ra = rd_cnt_q;
`endif
  end

  // Read side: whole pipeline advances only when the output slot frees up.
  always_comb begin
    adv   = !vld_pipe_q[1] || DataOutReady;
    issue = adv && (rst_q == R_DRAIN || full_q[rd_bank_q]);
    iss_meta.l     = il;
    iss_meta.k     = ik;
    iss_meta.first = (rd_cnt_q == '0);
    iss_meta.last  = &rd_cnt_q;
    iss_meta.bank  = rd_bank_q;
    iss_meta.fnum  = fnum_q[rd_bank_q];
    rst_d      = rst_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    out_d      = out_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    if (issue) begin
      if (&rd_cnt_q) begin
        rd_cnt_d  = '0;
        rd_bank_d = ~rd_bank_q;
        rst_d     = R_IDLE;
      end else begin
        rd_cnt_d = rd_cnt_q + AW'(1);
        rst_d    = R_DRAIN;
      end
    end
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[0], issue};
      s1_d       = iss_meta;
      if (vld_pipe_q[0]) begin
        out_d                = s1_q;
        {out_re_d, out_im_d} = rdata_q;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (we)    mem[{wr_bank_q, waddr}] <= {DataInRe, DataInIm};
    if (issue) rdata_q <= mem[{rd_bank_q, ra}];
  end

  always_ff @(posedge Clk or negedge ARstN) begin
    if (!ARstN) begin
      wst_q      <= W_IDLE;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      full_q     <= '0;
      fnum_q     <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rst_q      <= R_IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      out_q      <= '0;
      out_re_q   <= '0;
      out_im_q   <= '0;
    end else begin
      wst_q      <= wst_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      full_q     <= full_d;
      fnum_q     <= fnum_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      rst_q      <= rst_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      out_q      <= out_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
    end
  end

  assign DataOutValid  = vld_pipe_q[1];
  assign DataOutRe     = out_re_q;
  assign DataOutIm     = out_im_q;
  assign FrameStartOut = vld_pipe_q[1] & out_q.first;
  assign FrameEndOut   = vld_pipe_q[1] & out_q.last;
  assign FrameNumOut   = out_q.fnum;
  assign DelayIdx      = out_q.l;
  assign DopplerIdx    = out_q.k;
  assign Overflow      = ovf_q;
  assign FrameErr      = ferr_q;
endmodule

// File: tb/tb_otfs_dd_grid_buffer.sv
// Directed-sequence bench for otfs_dd_grid_buffer (M=4, N=2) with a grid-order reference queue.
module tb_otfs_dd_grid_buffer;
  localparam int M = 4, N = 2, DW = 12, MN = M * N;

  logic          Clk = 1'b0;
  logic          ARstN, ModDataInValid, FrameBeginIn, DataOutReady;
  logic [7:0]    FrameNumIn;
  logic [DW-1:0] DataInRe, DataInIm;
  logic          DataOutValid, FrameStartOut, FrameEndOut, Overflow, FrameErr;
  logic [DW-1:0] DataOutRe, DataOutIm;
  logic [7:0]    FrameNumOut;
  logic [1:0]    DelayIdx;
  logic          DopplerIdx;

  otfs_dd_grid_buffer #(.M(M), .N(N), .DW(DW)) dut (
    .Clk(Clk), .ARstN(ARstN), .ModDataInValid(ModDataInValid), .FrameBeginIn(FrameBeginIn),
    .FrameNumIn(FrameNumIn), .DataInRe(DataInRe), .DataInIm(DataInIm),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReady), .DataOutRe(DataOutRe),
    .DataOutIm(DataOutIm), .FrameStartOut(FrameStartOut), .FrameEndOut(FrameEndOut),
    .FrameNumOut(FrameNumOut), .DelayIdx(DelayIdx), .DopplerIdx(DopplerIdx),
    .Overflow(Overflow), .FrameErr(FrameErr));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] re, im;
    int            l, k;
    bit            s, e;
    logic [7:0]    fn;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] sre[MN], sim[MN];
  int            n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(DataOutValid), 0);
    chk({tag, "_re"},    32'(DataOutRe), 0);
    chk({tag, "_im"},    32'(DataOutIm), 0);
    chk({tag, "_start"}, 32'(FrameStartOut), 0);
    chk({tag, "_end"},   32'(FrameEndOut), 0);
    chk({tag, "_fnum"},  32'(FrameNumOut), 0);
    chk({tag, "_didx"},  32'(DelayIdx), 0);
    chk({tag, "_kidx"},  32'(DopplerIdx), 0);
    chk({tag, "_ovf"},   32'(Overflow), 0);
    chk({tag, "_ferr"},  32'(FrameErr), 0);
  endtask

  // Reference: output position o maps to grid cell (l,k); the symbol there is input j = k*M + l.
  task automatic push_expected(input logic [7:0] fn);
    exp_t e;
    for (int o = 0; o < MN; o++) begin
`ifdef OTFS_GRID_TRANSPOSE_EN
      e.l = o / N; e.k = o % N;
`else
      e.l = o % M; e.k = o / M;
`endif
      e.re = sre[e.k * M + e.l];
      e.im = sim[e.k * M + e.l];
      e.s  = (o == 0);
      e.e  = (o == MN - 1);
      e.fn = fn;
      q.push_back(e);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] fn, input bit seq, input int base, input bit keep);
    for (int j = 0; j < n; j++) begin
      @(negedge Clk);
      ModDataInValid = 1'b1;
      FrameBeginIn   = (j == 0);
      FrameNumIn     = (j == 0) ? fn : 8'($urandom);
      DataInRe       = seq ? DW'(base + j) : DW'($urandom);
      DataInIm       = DW'($urandom);
      sre[j] = DataInRe;
      sim[j] = DataInIm;
    end
    if (keep) push_expected(fn);
  endtask

  task automatic idle_cycle();
    @(negedge Clk);
    ModDataInValid = 1'b0;
    FrameBeginIn   = 1'b0;
  endtask

  task automatic drain(input int nexp, input bit toggle);
    int got = 0, cyc = 0;
    bit held = 0;
    logic [DW-1:0] hre, him;
    logic hs, he, hk;
    logic [7:0] hfn;
    logic [1:0] hl;
    exp_t e;
    while (got < nexp && cyc < 300) begin
      if (held) begin
        chk("hold_valid", 32'(DataOutValid), 1);
        chk("hold_re", 32'(DataOutRe), 32'(hre));
        chk("hold_im", 32'(DataOutIm), 32'(him));
        chk("hold_meta", {20'd0, FrameStartOut, FrameEndOut, FrameNumOut, DelayIdx, DopplerIdx},
                         {20'd0, hs, he, hfn, hl, hk});
      end
      DataOutReady = toggle ? (cyc % 3 == 0) : 1'b1;
      if (DataOutValid && DataOutReady) begin
        if (q.size() != 0) e = q.pop_front();
        chk("out_re", 32'(DataOutRe), 32'(e.re));
        chk("out_im", 32'(DataOutIm), 32'(e.im));
        chk("out_didx", 32'(DelayIdx), 32'(e.l));
        chk("out_kidx", 32'(DopplerIdx), 32'(e.k));
        chk("out_start", 32'(FrameStartOut), 32'(e.s));
        chk("out_end", 32'(FrameEndOut), 32'(e.e));
        chk("out_fnum", 32'(FrameNumOut), 32'(e.fn));
        got++;
      end
      held = DataOutValid && !DataOutReady;
      hre = DataOutRe; him = DataOutIm; hs = FrameStartOut; he = FrameEndOut;
      hfn = FrameNumOut; hl = DelayIdx; hk = DopplerIdx;
      @(negedge Clk);
      cyc++;
    end
    chk("drain_count", 32'(got), 32'(nexp));
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (DataOutValid) cnt++;
    end
  endtask

  initial begin
    int lat, cnt;
    ARstN = 1'b0; ModDataInValid = 1'b0; FrameBeginIn = 1'b0; FrameNumIn = '0;
    DataInRe = '0; DataInIm = '0; DataOutReady = 1'b1;
    #1;
    chk_zero_outputs("reset");
    repeat (2) @(negedge Clk);
    ARstN = 1'b1;

    // symbols without a frame start are ignored
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      ModDataInValid = 1'b1; FrameBeginIn = 1'b0; DataInRe = DW'($urandom);
    end
    idle_cycle();
    count_valids(6, cnt);
    chk("stray_no_output", 32'(cnt), 0);
    chk("stray_no_ferr", 32'(FrameErr), 0);

    // single frame, latency from last write
    send_frame(MN, 8'h05, 1, 0, 1);
    idle_cycle();
    lat = 0;
    while (!DataOutValid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    chk("first_out_latency", 32'(lat), 2);
    drain(MN, 0);

    // backpressure 1,0,0,...
    send_frame(MN, 8'($urandom), 1, 0, 1);
    idle_cycle();
    drain(MN, 1);

    // ping-pong then overflow on third frame
    DataOutReady = 1'b0;
    send_frame(MN, 8'h01, 0, 0, 1);
    send_frame(MN, 8'h02, 0, 0, 1);
    send_frame(MN, 8'h03, 0, 0, 0);
    idle_cycle();
    chk("overflow_set", 32'(Overflow), 1);
    chk("ferr_clear", 32'(FrameErr), 0);
    drain(2 * MN, 0);
    count_valids(20, cnt);
    chk("frame3_absent", 32'(cnt), 0);

    // early restart
    send_frame(3, 8'h20, 0, 0, 0);
    send_frame(MN, 8'h21, 1, 10, 1);
    idle_cycle();
    chk("frame_err_set", 32'(FrameErr), 1);
    chk("overflow_sticky", 32'(Overflow), 1);
    drain(MN, 0);

    // async reset with output index 3 on the bus
    send_frame(MN, 8'($urandom), 0, 0, 1);
    idle_cycle();
    drain(3, 0);
    chk("pre_reset_valid", 32'(DataOutValid), 1);
    ARstN = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    q.delete();
    @(negedge Clk);
    ARstN = 1'b1;
    send_frame(MN, 8'($urandom), 0, 0, 1);
    idle_cycle();
    drain(MN, 0);
    chk("queue_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
